// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus_uart peripheral.
// Holds the register offsets, the STATUS and CONTROL bit positions, the serial FSM state type
// and the RX FIFO depth used when UART_FIFO_EN is defined.
package bus_uart_pkg;

  // Register offsets, decoded from address[1:0].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit indices.
  localparam int ST_RDRF    = 0;
  localparam int ST_TDRE    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FE      = 3;
  localparam int ST_TX_BUSY = 4;
  localparam int ST_IRQ     = 7;

  // CONTROL bit indices.
  localparam int CTRL_RIE = 0;
  localparam int CTRL_TIE = 1;

  // Depth of the optional RX FIFO.
  localparam int FIFO_DEPTH = 8;

  // State type shared by the TX and RX serial FSMs.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/bus_uart_if.sv
// CPU-side bus of the UART: chip select, register select, direction, data in and out, and the
// active-low interrupt line.
interface bus_uart_if;
  logic       cs;
  logic [1:0] rs;
  logic       rWb;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       nIrq;

  modport master (output cs, rs, rWb, dataIn, input dataOut, nIrq);
  modport slave  (input cs, rs, rWb, dataIn, output dataOut, nIrq);
endinterface

// File: rtl/bus_uart_rx_fifo.sv
// 8-entry RX FIFO with 9-bit entries {fe, data}. It is used only when UART_FIFO_EN is defined.
// The instantiating logic must never pop when the FIFO is empty.
// It must also never push when the FIFO is full, unless a pop happens on the same edge.
module uart_rx_fifo
  import bus_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       empty,
  output logic       full
);

  logic [8:0] mem_q [FIFO_DEPTH];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;

  // Pointer and occupancy update; 3-bit pointers wrap at 8 on their own.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 3'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  // NOTE: the array has no reset. Its contents are only visible once count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 4'd0);
  assign full  = (count_q == 4'(FIFO_DEPTH));

endmodule

// File: rtl/bus_uart.sv
// bus_uart: byte-wide 8N1 UART peripheral on the 65C02 bus.
// Registers: DATA, STATUS, CONTROL. The interrupt output nIrq is active low.
// Optional feature macro UART_FIFO_EN: when defined, the single RX holding register is replaced
// by the 8-entry uart_rx_fifo. TX is single-buffered in both builds.
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic         clk,
  input  logic         reset,
  bus_uart_if.slave    bus,
  input  logic         rxd,
  output logic         txd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  // Bus decode: writes and read side effects commit on the edge where cs is high.
  logic wr_data, wr_ctrl, rd_data;
  assign wr_data = bus.cs & ~bus.rWb & (bus.rs == REG_DATA);
  assign wr_ctrl = bus.cs & ~bus.rWb & (bus.rs == REG_CTRL);
  assign rd_data = bus.cs &  bus.rWb & (bus.rs == REG_DATA);

  // ---------------- TX ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tdre_q, tdre_d;
  logic        txd_q, txd_d;
  logic [1:0]  ctrl_q, ctrl_d;

  // TX holding register, TX FSM and CONTROL next-state.
  // A load from the holding register requires tdre_q=0, and a CPU store requires tdre_q=1.
  // The two therefore never collide on tdre_d.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tdre_d     = tdre_q;
    txd_d      = txd_q;
    ctrl_d     = wr_ctrl ? bus.dataIn[1:0] : ctrl_q;
    if (wr_data && tdre_q) begin
      tx_hold_d = bus.dataIn;
      tdre_d    = 1'b0;
    end
    unique case (tx_state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!tdre_q) begin
          tx_shift_d = tx_hold_q;
          tdre_d     = 1'b1;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (!tdre_q) begin
            // A byte is already waiting, so its start bit follows the stop bit with no idle gap.
            tx_shift_d = tx_hold_q;
            tdre_d     = 1'b1;
            tx_state_d = S_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_deliver, rx_new_fe;

  // RX FSM on the synchronized line. It detects a falling edge, centres on the start bit and
  // then samples once per bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_deliver = 1'b0;
    rx_new_fe  = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          rx_deliver = 1'b1;
          rx_new_fe  = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX delivery and flags ----------------
  logic       rdrf, fe;
  logic [7:0] rx_byte;
  logic       ovr_q, ovr_d;

`ifdef UART_FIFO_EN
  logic       fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [8:0] fifo_head;

  // A pop on the same edge frees the slot, so a push into a full FIFO is accepted then.
  always_comb begin
    fifo_pop  = rd_data & ~fifo_empty;
    fifo_push = rx_deliver & (~fifo_full | fifo_pop);
    ovr_d     = rd_data ? 1'b0 : ovr_q;
    if (rx_deliver && fifo_full && !fifo_pop) ovr_d = 1'b1;
  end

  uart_rx_fifo u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({rx_new_fe, rx_shift_q}),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rdrf    = ~fifo_empty;
  assign fe      = fifo_head[8] & ~fifo_empty;
  assign rx_byte = fifo_head[7:0];
`else
  logic       rdrf_q, rdrf_d;
  logic       fe_q, fe_d;
  logic [7:0] rx_data_q, rx_data_d;

  // Single holding register. A DATA read on the same edge as a delivery makes room for the new
  // byte, so no overrun is flagged.
  always_comb begin
    rdrf_d    = rdrf_q;
    ovr_d     = ovr_q;
    fe_d      = fe_q;
    rx_data_d = rx_data_q;
    if (rd_data) begin
      rdrf_d = 1'b0;
      ovr_d  = 1'b0;
      fe_d   = 1'b0;
    end
    if (rx_deliver) begin
      if (!rdrf_q || rd_data) begin
        rx_data_d = rx_shift_q;
        rdrf_d    = 1'b1;
        fe_d      = rx_new_fe;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Holding register and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdrf_q    <= 1'b0;
      fe_q      <= 1'b0;
      rx_data_q <= '0;
    end else begin
      rdrf_q    <= rdrf_d;
      fe_q      <= fe_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rdrf    = rdrf_q;
  assign fe      = fe_q;
  assign rx_byte = rx_data_q;
`endif

  // ---------------- State registers ----------------
  // TX, RX, synchronizer, CONTROL and OVR registers. Reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tdre_q     <= 1'b1;
      txd_q      <= 1'b1;
      ctrl_q     <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      ovr_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tdre_q     <= tdre_d;
      txd_q      <= txd_d;
      ctrl_q     <= ctrl_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      ovr_q      <= ovr_d;
    end
  end

  // ---------------- Bus read side ----------------
  logic       irq, tx_busy;
  logic [7:0] status;

  assign tx_busy = (tx_state_q != S_IDLE);
  assign irq     = (ctrl_q[CTRL_RIE] & rdrf) | (ctrl_q[CTRL_TIE] & tdre_q);

  // Assemble STATUS from the registered flags.
  always_comb begin
    status             = 8'h00;
    status[ST_RDRF]    = rdrf;
    status[ST_TDRE]    = tdre_q;
    status[ST_OVR]     = ovr_q;
    status[ST_FE]      = fe;
    status[ST_TX_BUSY] = tx_busy;
    status[ST_IRQ]     = irq;
  end

  // Read mux: combinational from rs, and zero whenever the chip is not selected.
  always_comb begin
    bus.dataOut = 8'h00;
    if (bus.cs) begin
      unique case (bus.rs)
        REG_DATA:   bus.dataOut = rx_byte;
        REG_STATUS: bus.dataOut = status;
        REG_CTRL:   bus.dataOut = {6'b0, ctrl_q};
        default:    bus.dataOut = 8'h00;
      endcase
    end
  end

  assign bus.nIrq = ~irq;
  assign txd      = txd_q;

endmodule

// File: tb/tb_bus_uart.sv
// Scoreboard bench for bus_uart with CLKS_PER_BIT=4.
// Stimulus pushes the expected value and raises sample_req. A monitor process pops the
// expectation on the following negedge and compares it against the selected DUT output.
module tb_bus_uart;
  localparam int CPB    = 4;
  localparam int K_DOUT = 0;
  localparam int K_TXD  = 1;
  localparam int K_NIRQ = 2;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd;
  logic sample_req = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t sb_e;

  bus_uart_if bus_if ();

  bus_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Monitor: consume one expectation per sample request.
  always @(negedge clk) begin
    if (sample_req) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        sb_e = sb_q.pop_front();
        case (sb_e.kind)
          K_DOUT:  check(sb_e.name, bus_if.dataOut, sb_e.exp);
          K_TXD:   check(sb_e.name, {7'b0, txd}, sb_e.exp);
          default: check(sb_e.name, {7'b0, bus_if.nIrq}, sb_e.exp);
        endcase
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample(input int kind, input logic [7:0] exp, input string name);
    sb_q.push_back('{name, kind, exp});
    sample_req = 1'b1;
    @(posedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] rs, input logic [7:0] exp, input string name);
    bus_if.cs  = 1'b1;
    bus_if.rWb = 1'b1;
    bus_if.rs  = rs;
    sample(K_DOUT, exp, name);
    bus_if.cs  = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] rs, input logic [7:0] data);
    bus_if.cs     = 1'b1;
    bus_if.rWb    = 1'b0;
    bus_if.rs     = rs;
    bus_if.dataIn = data;
    @(posedge clk);
    #1;
    bus_if.cs     = 1'b0;
    bus_if.rWb    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
  endtask

  logic [9:0] tx_frame;

  initial begin
    bus_if.cs     = 1'b0;
    bus_if.rWb    = 1'b1;
    bus_if.rs     = 2'd0;
    bus_if.dataIn = 8'h00;
    tick(3);
    reset = 1'b0;

    // Reset state.
    sample(K_TXD,  8'h01, "reset_txd");
    sample(K_NIRQ, 8'h01, "reset_nirq");
    bus_if.rs = 2'd1;
    sample(K_DOUT, 8'h00, "reset_dout_cs0");
    bus_read(2'd1, 8'h02, "reset_status");
    bus_read(2'd2, 8'h00, "reset_ctrl");
    bus_read(2'd3, 8'h00, "reset_rs3");

    // TX 0xA5: start, eight data bits LSB first, stop; four clocks per bit.
    tx_frame = {1'b1, 8'hA5, 1'b0};
    bus_write(2'd0, 8'hA5);
    bus_read(2'd1, 8'h00, "tx_tdre_clear");
    bus_read(2'd1, 8'h12, "tx_tdre_set");
    for (int i = 0; i < 10; i++) begin
      sample(K_TXD, {7'b0, tx_frame[i]}, $sformatf("tx_bit%0d", i));
      bus_read(2'd1, 8'h12, $sformatf("tx_busy%0d", i));
      tick(2);
    end
    bus_read(2'd1, 8'h02, "tx_done_status");
    sample(K_TXD, 8'h01, "tx_done_txd");

    // RX single frame.
    send_frame(8'h3C, 1'b1);
    bus_read(2'd1, 8'h03, "rx_rdrf_set");
    bus_read(2'd0, 8'h3C, "rx_data_3c");
    bus_read(2'd1, 8'h02, "rx_rdrf_clear");

    // Two frames with no read in between.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
`ifdef UART_FIFO_EN
    bus_read(2'd1, 8'h03, "two_status_fifo");
    bus_read(2'd0, 8'h11, "two_data_first");
    bus_read(2'd0, 8'h22, "two_data_second");
`else
    bus_read(2'd1, 8'h07, "two_status_ovr");
    bus_read(2'd0, 8'h11, "two_data_first");
`endif
    bus_read(2'd1, 8'h02, "two_status_clear");

    // Framing error: stop bit 0, byte still delivered.
    send_frame(8'h55, 1'b0);
    bus_read(2'd1, 8'h0B, "fe_status");
    bus_read(2'd0, 8'h55, "fe_data");
    bus_read(2'd1, 8'h02, "fe_clear");

    // One-cycle glitch is rejected as a false start.
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(60);
    bus_read(2'd1, 8'h02, "glitch_status");

    // CONTROL keeps only its two defined bits.
    bus_write(2'd2, 8'hFF);
    bus_read(2'd2, 8'h03, "ctrl_ff_rb");
    bus_write(2'd2, 8'h00);

    // Interrupt paths.
    bus_write(2'd2, 8'h01);
    sample(K_NIRQ, 8'h01, "irq_rie_empty");
    send_frame(8'h7E, 1'b1);
    sample(K_NIRQ, 8'h00, "irq_rx_assert");
    bus_read(2'd1, 8'h83, "irq_status");
    bus_read(2'd0, 8'h7E, "irq_data");
    sample(K_NIRQ, 8'h01, "irq_rx_cleared");
    bus_write(2'd2, 8'h02);
    sample(K_NIRQ, 8'h00, "irq_tie_assert");
    bus_read(2'd2, 8'h02, "irq_ctrl_rb");
    bus_write(2'd2, 8'h00);
    sample(K_NIRQ, 8'h01, "irq_masked");

    // Reset mid-frame aborts transmission.
    bus_write(2'd0, 8'h00);
    tick(8);
    sample(K_TXD, 8'h00, "abort_txd_mid");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sample(K_TXD, 8'h01, "abort_txd_idle");
    bus_read(2'd1, 8'h02, "abort_status");

    tick(2);
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
